// File: rtl/packet_eject_local.sv
// Local ejection sink: buffers router-delivered packets, drains one per EJECT_CYCLE
// cycles and accumulates latency/routing statistics. Optional macro: EJECT_PER_SRC_STATS_EN.
module packet_eject_local #(
  parameter int NUM_NODES            = 8,
  parameter int ROUTER_ID            = 0,
  parameter int PACKET_SIZE          = 49,
  parameter int BUFFER_SIZE          = 4,
  parameter int EJECT_CYCLE          = 1,
  parameter int NUM_PACKETS_EXPECTED = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [15:0]               clk_counter,
  input  logic [PACKET_SIZE-1:0]    in_packet,
  output logic                      in_ready,
  output logic [63:0]               total_packet_recv,
  output logic [63:0]               total_latency,
  output logic [15:0]               max_latency,
  output logic [15:0]               misroute_cnt,
  output logic                      done,
  output logic [NUM_NODES*16-1:0]   src_recv_cnt
);

  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam int ENT_W = PACKET_SIZE - 1;

  // Handshake: a packet transfers on a clock edge where in_packet[MSB]=1 and in_ready=1.
  // in_ready depends only on registered occupancy, so the sender may hold valid freely.
  logic [ENT_W-1:0] mem_q [BUFFER_SIZE];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      timer_q, timer_d;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;
  logic [15:0]      head_dst;
  logic [15:0]      head_ts;
  logic [15:0]      pop_lat;
  logic             pop_good;

  logic             stg_vld_q;
  logic [15:0]      stg_lat_q;
  logic             stg_good_q;

  logic [63:0]      recv_q, recv_d;
  logic [63:0]      lat_sum_q, lat_sum_d;
  logic [15:0]      max_q, max_d;
  logic [15:0]      mis_q, mis_d;
  logic             done_q, done_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready = (count_q != CNT_W'(BUFFER_SIZE));
  assign push     = in_packet[PACKET_SIZE-1] && in_ready;
  assign pop      = (count_q != '0) && (timer_q == 16'd0);
  assign head     = mem_q[rd_ptr_q];
  assign head_dst = head[15:0];
  assign head_ts  = head[47:32];
  assign pop_lat  = clk_counter - head_ts;

`ifdef EJECT_PER_SRC_STATS_EN
  localparam int SRC_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  logic [SRC_W-1:0] stg_src_q;
  logic [15:0]      src_cnt_q [NUM_NODES];

  // A source id outside the ring is treated as a routing error.
  assign pop_good = (head_dst == 16'(ROUTER_ID)) && (head[31:16] < 16'(NUM_NODES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_src_q <= '0;
      for (int i = 0; i < NUM_NODES; i++) src_cnt_q[i] <= 16'd0;
    end else begin
      if (pop) stg_src_q <= head[16 +: SRC_W];
      if (stg_vld_q && stg_good_q && (src_cnt_q[stg_src_q] != 16'hFFFF))
        src_cnt_q[stg_src_q] <= src_cnt_q[stg_src_q] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_NODES; g++) begin : g_src_out
    assign src_recv_cnt[g*16 +: 16] = src_cnt_q[g];
  end
`else
  logic unused_head_src;
  assign unused_head_src = ^head[31:16];
  assign pop_good        = (head_dst == 16'(ROUTER_ID));
  assign src_recv_cnt    = '0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_packet[ENT_W-1:0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    timer_d  = timer_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // The timer keeps running down even while the FIFO is empty.
    if (pop)                    timer_d = 16'(EJECT_CYCLE - 1);
    else if (timer_q != 16'd0) timer_d = timer_q - 16'd1;
  end

  always_comb begin
    recv_d    = recv_q;
    lat_sum_d = lat_sum_q;
    max_d     = max_q;
    mis_d     = mis_q;
    if (stg_vld_q) begin
      if (stg_good_q) begin
        recv_d    = recv_q + 64'd1;
        lat_sum_d = lat_sum_q + {48'd0, stg_lat_q};
        if (stg_lat_q > max_q) max_d = stg_lat_q;
      end else if (mis_q != 16'hFFFF) begin
        mis_d = mis_q + 16'd1;
      end
    end
    done_d = done_q | (recv_d >= 64'(NUM_PACKETS_EXPECTED));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= 16'd0;
      stg_vld_q  <= 1'b0;
      stg_lat_q  <= 16'd0;
      stg_good_q <= 1'b0;
      recv_q     <= 64'd0;
      lat_sum_q  <= 64'd0;
      max_q      <= 16'd0;
      mis_q      <= 16'd0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      stg_vld_q  <= pop;
      if (pop) begin
        stg_lat_q  <= pop_lat;
        stg_good_q <= pop_good;
      end
      recv_q     <= recv_d;
      lat_sum_q  <= lat_sum_d;
      max_q      <= max_d;
      mis_q      <= mis_d;
      done_q     <= done_d;
    end
  end

  assign total_packet_recv = recv_q;
  assign total_latency     = lat_sum_q;
  assign max_latency       = max_q;
  assign misroute_cnt      = mis_q;
  assign done              = done_q;

endmodule
